// File: rtl/idiv_if.sv
// Handshake and data bundle for the iterative integer divider (idiv).
// Signal names follow the divider's established port names.
interface idiv_if;
    logic        clkEn;
    logic        en;
    logic [2:0]  op;
    logic [64:0] R;
    logic [64:0] C;
    logic [64:0] Res;
    logic [5:0]  flg;
    logic        busy;
    logic        done;

    modport master (output clkEn, en, op, R, C, input Res, flg, busy, done);
    modport slave  (input clkEn, en, op, R, C, output Res, flg, busy, done);
endinterface

// File: rtl/idiv.sv
// Restoring radix-2 integer divider, 32/64-bit, signed/unsigned, quotient or remainder.
// Optional macro IDIV_EARLY_OUT_EN skips the leading-zero iterations of |dividend|.
//
// state | meaning
// IDLE  | waiting for a start request
// PREP  | take operand magnitudes, record signs, load counter
// ITER  | one quotient bit per enabled cycle, counter counts down
// FIX   | apply signs, select quotient/remainder, compute flags
// DONE  | result valid, done pulse; a new start may be accepted here
module idiv (
    input  logic   clk,
    input  logic   rst,
    idiv_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [63:0] dvd_raw, dvs_raw, dvs_abs, quo, rem;
    logic [6:0]  cnt;
    logic        op_short, op_rem, op_signed;
    logic        q_neg, r_neg, dz, ovf;
    logic [64:0] res_q;
    logic [5:0]  flg_q;

    logic [63:0] mask, mask_in, min_val, r_abs, c_abs, quo_init;
    logic        r_sign, c_sign, div_zero, ovf_p, skip_iter, accept;
    logic [6:0]  cnt_init;
    logic [64:0] rem_sh, diff;
    logic        ge;
    logic [63:0] rem_nxt, q_mag, q_fix, r_fix, res_fix;
    logic [5:0]  flg_fix;
    logic        unused_ok;

    assign unused_ok = ^{bus.R[64], bus.C[64]};

    assign mask_in = bus.op[2] ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    assign mask    = op_short  ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    assign min_val = op_short  ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
    assign accept  = bus.en && (state == IDLE || state == DONE);

    // Operand preparation, evaluated while in PREP
    always_comb begin
        r_sign   = op_short ? dvd_raw[31] : dvd_raw[63];
        c_sign   = op_short ? dvs_raw[31] : dvs_raw[63];
        r_abs    = (op_signed && r_sign) ? ((-dvd_raw) & mask) : dvd_raw;
        c_abs    = (op_signed && c_sign) ? ((-dvs_raw) & mask) : dvs_raw;
        div_zero = (dvs_raw == 64'd0);
        ovf_p    = op_signed && (dvd_raw == min_val) && (dvs_raw == mask);
`ifdef IDIV_EARLY_OUT_EN
        cnt_init = 7'd0;
        for (int i = 0; i < 64; i++) begin
            if (r_abs[i]) cnt_init = 7'(i + 1);
        end
        // Align the leading one to bit 63 so the first iteration consumes it.
        quo_init  = r_abs << (7'd64 - cnt_init);
        skip_iter = div_zero || (cnt_init == 7'd0);
`else
        cnt_init  = op_short ? 7'd32 : 7'd64;
        quo_init  = op_short ? (r_abs << 32) : r_abs;
        skip_iter = div_zero;
`endif
    end

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        rem_sh  = {rem, quo[63]};
        diff    = rem_sh - {1'b0, dvs_abs};
        ge      = ~diff[64];
        rem_nxt = ge ? diff[63:0] : rem_sh[63:0];
    end

    always_comb begin
        q_mag = quo & mask;
        q_fix = q_neg ? ((-q_mag) & mask) : q_mag;
        r_fix = r_neg ? ((-rem) & mask) : rem;
        if (dz) begin
            q_fix = mask;
            r_fix = dvd_raw;
        end
        res_fix = op_rem ? r_fix : q_fix;
        flg_fix = {dz, ovf, 1'b0, (op_short ? res_fix[31] : res_fix[63]),
                   ~|res_fix, ~^res_fix[7:0]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (bus.clkEn)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.en) state_nxt = PREP;
            PREP: state_nxt = skip_iter ? FIX : ITER;
            ITER: if (cnt == 7'd1) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = bus.en ? PREP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_raw   <= '0;
            dvs_raw   <= '0;
            dvs_abs   <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            op_short  <= 1'b0;
            op_rem    <= 1'b0;
            op_signed <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            res_q     <= '0;
            flg_q     <= '0;
        end else if (bus.clkEn) begin
            if (accept) begin
                dvd_raw   <= bus.R[63:0] & mask_in;
                dvs_raw   <= bus.C[63:0] & mask_in;
                op_short  <= bus.op[2];
                op_rem    <= bus.op[1];
                op_signed <= bus.op[0];
            end
            case (state)
                PREP: begin
                    quo     <= quo_init;
                    dvs_abs <= c_abs;
                    rem     <= '0;
                    cnt     <= skip_iter ? 7'd0 : cnt_init;
                    q_neg   <= op_signed && (r_sign ^ c_sign);
                    r_neg   <= op_signed && r_sign;
                    dz      <= div_zero;
                    ovf     <= ovf_p;
                end
                ITER: begin
                    rem <= rem_nxt;
                    quo <= {quo[62:0], ge};
                    cnt <= cnt - 7'd1;
                end
                FIX: begin
                    res_q <= {1'b0, res_fix};
                    flg_q <= flg_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.Res  = res_q;
    assign bus.flg  = flg_q;
    assign bus.busy = (state == PREP) || (state == ITER) || (state == FIX);
    assign bus.done = (state == DONE);
endmodule

// File: doc/idiv.md
IDIV -- requirements
Module: idiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port clkEn, input, 1 bit: pipeline advance enable; when low, all state holds.
REQ-004 SHALL have port en, input, 1 bit: start request.
REQ-005 SHALL have port op, input, 3 bits: {short, rem, signed}; short=1 selects 32-bit, rem=1 returns remainder, signed=1 selects signed.
REQ-006 SHALL have port R, input, 65 bits: dividend in [63:0]; bit 64 ignored.
REQ-007 SHALL have port C, input, 65 bits: divisor in [63:0]; bit 64 ignored.
REQ-008 SHALL have port Res, output, 65 bits: result; bit 64 always 0.
REQ-009 SHALL have port flg, output, 6 bits: {CF,OF,AF,SF,ZF,PF}.
REQ-010 SHALL have port busy, output, 1 bit: operation in flight.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse when Res and flg are valid.

Function
REQ-012 SHALL accept a start on a cycle with clkEn=1, en=1, busy=0, latching R, C and op; en while busy SHALL be ignored.
REQ-013 SHALL implement FSM IDLE->PREP->ITER->FIX->DONE->IDLE, advancing only when clkEn=1.
REQ-014 PREP SHALL take the absolute values of the operands when signed=1, using [31:0] when short=1 and [63:0] otherwise, and SHALL record the quotient sign (XOR of operand signs) and the remainder sign (dividend sign).
REQ-015 ITER SHALL perform restoring radix-2 division at one quotient bit per clkEn cycle, N=64 iterations (N=32 when short), with a down-counter that exits to FIX at 0.
REQ-016 FIX SHALL negate the quotient or remainder per the recorded sign and select the quotient or remainder per rem.
REQ-017 32-bit results SHALL be zero-extended into Res[63:0].
REQ-018 A divisor of 0 SHALL skip ITER (PREP->FIX) and SHALL give quotient all-ones (width-masked), remainder = dividend, and CF=1.
REQ-019 Signed MIN/-1 SHALL give quotient = MIN, remainder = 0, and OF=1.
REQ-020 In all other cases CF=0 and OF=0.
REQ-021 Signed quotients SHALL truncate toward zero; the remainder SHALL carry the sign of the dividend.
REQ-022 flg SHALL be set as follows: AF=0; SF = result bit 63 (bit 31 if short); ZF = ~|result; PF = ~^result[7:0].
REQ-023 DONE SHALL assert done for exactly one clkEn cycle; Res and flg SHALL hold their values until the next done.
REQ-024 busy SHALL be high in PREP, ITER and FIX, and low in IDLE and DONE; a start SHALL be accepted in the DONE cycle.
REQ-025 Nominal latency from the accept cycle to done, with clkEn held at 1, SHALL be N+3 cycles; divide-by-zero latency SHALL be 3 cycles.

Reset
REQ-026 rst SHALL force IDLE regardless of clkEn.
REQ-027 Reset values SHALL be Res=0, flg=0, busy=0, done=0, counter=0.
REQ-028 An operation interrupted by reset SHALL be discarded, with no done pulse.

Configuration
REQ-029 The macro IDIV_EARLY_OUT_EN SHALL control early-out.
REQ-030 With IDIV_EARLY_OUT_EN defined, PREP SHALL load the counter with the bit position of the leading one of |dividend| plus 1, pre-shift the dividend accordingly, and go to FIX directly on a zero dividend; latency SHALL be k+3 cycles with k ≤ N.
REQ-031 Without IDIV_EARLY_OUT_EN, the iteration count SHALL always be N.
REQ-032 Results and flags SHALL be identical with and without IDIV_EARLY_OUT_EN.

Verification
REQ-033 Unsigned 64-bit quotient: R=100, C=7, op=000 -> done at cycle 67, Res=14, flg ZF=0, PF=0 (0x0E has three ones).
REQ-034 Signed 64-bit remainder: R=-7, C=2, op=011 -> Res=0xFFFFFFFFFFFFFFFF (-1), SF=1; the quotient for op=001 is -3.
REQ-035 Divide by zero: R=0x1234, C=0, op=000 -> done at cycle 3, Res=all-ones, CF=1; op=010 -> Res=0x1234.
REQ-036 Signed 32-bit overflow: R=0x80000000, C=0xFFFFFFFF, op=101 -> Res=0x0000000080000000, OF=1, SF=1.
REQ-037 Stall and reset: start, hold clkEn=0 for 10 cycles mid-ITER -> done is delayed by exactly 10 cycles; assert rst mid-ITER -> busy=0 next cycle and no done pulse.
REQ-038 Back-to-back: a second start with en=1 in the DONE cycle is accepted; en pulsed while busy produces no extra result.
